// File: rtl/branch_predictor_if.sv
// Fetch-lookup, EX-update and statistics signals of the branch predictor.
// The core side drives through the master modport; the predictor uses slave.
interface branch_predictor_if;
   logic        rdy;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   modport master (
      output rdy, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
      input  pred_taken, pred_pc, stat_branches, stat_mispredicts
   );

   modport slave (
      input  rdy, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
      output pred_taken, pred_pc, stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and zero-latency lookup.
// Define BP_STATS_EN to build the branch/mispredict statistics counters.
module branch_predictor #(
   parameter int INDEX_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bp
);
   localparam int ENTRIES = 1 << INDEX_W;
   localparam int TAG_W   = 30 - INDEX_W;

   typedef logic [TAG_W-1:0] tag_t;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];
   tag_t               tag_q    [ENTRIES];
   tag_t               tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];

   logic [INDEX_W-1:0] if_idx, upd_idx;
   tag_t               if_tag, upd_tag;
   logic               lookup_hit, upd_hit;
   logic [3:0]         unused_pc_bits;

   assign if_idx  = bp.if_pc[INDEX_W+1:2];
   assign if_tag  = bp.if_pc[31:INDEX_W+2];
   assign upd_idx = bp.upd_pc[INDEX_W+1:2];
   assign upd_tag = bp.upd_pc[31:INDEX_W+2];
   assign unused_pc_bits = {bp.if_pc[1:0], bp.upd_pc[1:0]};

   // Lookup reads only registered state, so a same-cycle update is seen next cycle.
   assign lookup_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign bp.pred_taken = lookup_hit && ctr_q[if_idx][1];
   assign bp.pred_pc    = bp.pred_taken ? target_q[if_idx] : bp.if_pc + 32'd4;

   always_comb begin
      // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
      valid_d  = valid_q;
      ctr_d    = ctr_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (bp.upd_valid) begin
         if (upd_hit) begin
            target_d[upd_idx] = bp.upd_target;
            if (bp.upd_taken) begin
               if (ctr_q[upd_idx] != 2'd3) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
            end else begin
               if (ctr_q[upd_idx] != 2'd0) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end
         end else if (bp.upd_taken) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = bp.upd_target;
            ctr_d[upd_idx]    = 2'd2;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd0;
      end else if (bp.rdy) begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
      end
   end

   // NOTE: tag/target storage has no reset; the cleared valid bits make stale contents harmless.
   always_ff @(posedge clk) begin
      if (rst && bp.rdy) begin
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (bp.upd_valid) begin
         stat_branches_d = stat_branches_q + 32'd1;
         if (bp.upd_mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else if (bp.rdy) begin
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign bp.stat_branches    = stat_branches_q;
   assign bp.stat_mispredicts = stat_mispredicts_q;
`else
   logic unused_mispredict;

   assign unused_mispredict   = bp.upd_mispredict;
   assign bp.stat_branches    = 32'd0;
   assign bp.stat_mispredicts = 32'd0;
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 6; log2 of table entries, 64 entries.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have rdy  input  1  global enable; low freezes all state.
REQ-005 SHALL have if_pc  input  32  fetch PC to predict.
REQ-006 SHALL have pred_taken  output  1  prediction for if_pc is taken.
REQ-007 SHALL have pred_pc  output  32  next fetch PC.
REQ-008 SHALL have upd_valid  input  1  EX resolved a conditional branch or JAL this cycle.
REQ-009 SHALL have upd_pc  input  32  PC of the resolved instruction.
REQ-010 SHALL have upd_taken  input  1  resolved direction.
REQ-011 SHALL have upd_target  input  32  taken-path target, pc+imm.
REQ-012 SHALL have upd_mispredict  input  1  EX-detected mispredict, used only for statistics.
REQ-013 SHALL have stat_branches  output  32  resolved-branch count.
REQ-014 SHALL have stat_mispredicts  output  32  mispredict count.

Function
REQ-015 Table SHALL be direct-mapped, 2^INDEX_W entries; each entry holds valid, tag, 32-bit target and 2-bit saturating counter.
REQ-016 Index SHALL be pc[INDEX_W+1:2]; tag SHALL be pc[31:INDEX_W+2]; pc[1:0] SHALL be ignored.
REQ-017 Lookup SHALL be combinational, zero latency: hit = valid && tag match at if_pc's index.
REQ-018 pred_taken SHALL be hit && counter[1]; pred_pc SHALL be the entry target when pred_taken, else if_pc+4, with 32-bit wrap.
REQ-019 Updates SHALL occur on the rising edge only when rst=1, rdy=1 and upd_valid=1.
REQ-020 Update on hit at upd_pc's index: counter SHALL increment when upd_taken=1, saturating at 3; decrement when upd_taken=0, saturating at 0; target SHALL be overwritten with upd_target.
REQ-021 Update on miss (invalid or tag mismatch) with upd_taken=1: entry SHALL be allocated or replaced with valid=1, new tag, target=upd_target, counter=2 (weakly taken).
REQ-022 Update on miss with upd_taken=0: table SHALL be unchanged.
REQ-023 Same-cycle lookup and update to one index: lookup SHALL return pre-update contents; the new contents SHALL be visible from the next cycle.
REQ-024 Aliasing PCs with equal index and different tag SHALL evict each other only per REQ-021.
REQ-025 rdy=0 SHALL hold table and counters unchanged; lookup outputs SHALL remain live.

Reset
REQ-026 rst=0 at a rising edge SHALL clear every valid bit and counter to 0, zero the statistics counters, and take priority over a simultaneous update.
REQ-027 During and after reset, pred_taken SHALL be 0 and pred_pc SHALL be if_pc+4 until an entry is allocated.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight update; no partial entry write.

Configuration
REQ-029 Macro BP_STATS_EN SHALL gate the statistics feature.
REQ-030 With BP_STATS_EN defined: stat_branches SHALL increment per qualifying update (REQ-019); stat_mispredicts SHALL increment when upd_mispredict is also 1; both SHALL wrap modulo 2^32.
REQ-031 Without BP_STATS_EN: both ports SHALL remain present, tied to constant 0, with no counter registers.

Verification
REQ-032 Reset, then if_pc=0x0000_1000 -> pred_taken=0, pred_pc=0x0000_1004.
REQ-033 Update pc=0x1000, taken=1, target=0x0000_2000; next cycle if_pc=0x1000 -> pred_taken=1, pred_pc=0x2000; one not-taken update -> counter=1, pred_pc=0x1004.
REQ-034 Four taken updates at 0x1000 then one not-taken -> counter 3 saturates, then 2; prediction stays taken to 0x2000.
REQ-035 Entry allocated at 0x1000; taken update at 0x1100 (same index, INDEX_W=6) -> 0x1000 now misses (pred_pc=0x1004), 0x1100 hits.
REQ-036 Update and lookup of 0x1000 in the same cycle on an empty table -> that cycle pred_taken=0; next cycle pred_taken=1.
REQ-037 With BP_STATS_EN: 5 updates, 2 with upd_mispredict=1, one issued while rdy=0 -> stat_branches=4, stat_mispredicts equal to the flagged updates issued with rdy=1; rst=0 -> both 0.
